// File: rtl/midi_uart_rx_pkg.sv
// midi_pkg: shared types and constants for the MIDI IN receive path.
//   rx_state_t      - receiver FSM state encoding
//   MIDI_DATA_BITS  - data bits per MIDI frame (8N1)
//   MIDI_IDLE_LEVEL - line level of an idle MIDI current loop
package midi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned MIDI_DATA_BITS  = 8;
    localparam logic        MIDI_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/midi_uart_rx_if.sv
// midi_uart_rx_if: byte handshake between the MIDI receiver and the
// downstream byte FIFO / router control.
//   data_o    - received byte (FIFO data_i)
//   wr        - one-cycle FIFO write strobe
//   full_n    - FIFO not-full; low blocks the write
//   clr_err   - one-cycle clear of the sticky overrun flag
//   frame_err - one-cycle pulse on a bad stop bit
//   overrun   - sticky: a good byte was dropped on a full FIFO
//   busy      - receiver is mid-frame
// master: the receiver.  slave: the FIFO / router side.
interface midi_uart_rx_if;
    import midi_pkg::*;

    logic [MIDI_DATA_BITS-1:0] data_o;
    logic                      wr;
    logic                      full_n;
    logic                      clr_err;
    logic                      frame_err;
    logic                      overrun;
    logic                      busy;

    modport master (
        output data_o, wr, frame_err, overrun, busy,
        input  full_n, clr_err
    );

    modport slave (
        input  data_o, wr, frame_err, overrun, busy,
        output full_n, clr_err
    );

endinterface

// File: rtl/midi_uart_rx_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for asynchronous inputs.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronised output (2 cycles of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: oversampling 8N1 MIDI IN receiver feeding the byte FIFO.
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   rx_i   - raw MIDI IN line (idle high, asynchronous)
//   bus    - master side of midi_uart_rx_if: data_o/wr toward the FIFO,
//            full_n from it, frame_err/overrun/busy/clr_err with router control
// Each frame is sampled mid-bit: the start bit after CLKS_PER_BIT/2 cycles,
// then every CLKS_PER_BIT cycles for 8 data bits (LSB first) and the stop bit.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_i,
    midi_uart_rx_if.master bus
);

    localparam int unsigned        IDX_W     = $clog2(MIDI_DATA_BITS);
    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(MIDI_DATA_BITS - 1);

    rx_state_t                 state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [MIDI_DATA_BITS-1:0] shift;
    logic                      rx_s;

    sync_2ff #(
        .RST_VAL (MIDI_IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (rx_i),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            bus.data_o    <= '0;
            bus.wr        <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.wr        <= 1'b0;
            bus.frame_err <= 1'b0;

            // Clear first; a drop in the same cycle re-sets it below and wins.
            if (bus.clr_err) begin
                bus.overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_s != MIDI_IDLE_LEVEL) begin
                        state    <= START;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_s != MIDI_IDLE_LEVEL) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // Start bit did not survive to mid-bit: glitch.
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[MIDI_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s == MIDI_IDLE_LEVEL) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            if (bus.full_n) begin
                                bus.data_o <= shift;
                                bus.wr     <= 1'b1;
                            end else begin
                                bus.overrun <= 1'b1;
                            end
                        end else begin
                            bus.frame_err <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // Hold off until the line returns idle so a break
                    // cannot be mistaken for a stream of start bits.
                    if (rx_s == MIDI_IDLE_LEVEL) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
Serial MIDI receiver that sits directly upstream of the byte FIFO. It oversamples the MIDI IN line (8N1, LSB first) and deserialises each frame. Each valid byte is pushed into the FIFO with a single-cycle write strobe, gated by the FIFO's full_n. Framing errors and bytes dropped on a full FIFO are flagged to the router control logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per MIDI bit; must be even and >= 4.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter (derived; do not override).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
rx_i  input  1  raw MIDI IN line; idle high; asynchronous to clk.
full_n  input  1  FIFO not-full status; low means the FIFO cannot accept a write.
clr_err  input  1  synchronous clear of overrun; one-cycle pulse.
data_o  output  8  received byte; connects to FIFO data_i.
wr  output  1  FIFO write strobe; one-cycle pulse per accepted byte.
frame_err  output  1  one-cycle pulse when a stop bit samples low.
overrun  output  1  sticky flag: a valid byte was dropped because full_n was low.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - Synchroniser flops=1.
  - Counters=0, shift register=0.
  - data_o=0, wr=0, frame_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame aborts the frame with no wr and no flags.
- Input synchronisation: rx_i passes through 2 flops to give rx_s. All decisions use rx_s only. This adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rx_s==0, go to START and clear the counter.
- START: count CLKS_PER_BIT/2 cycles, then sample rx_s.
  - rx_s==0: go to DATA; counter=0, bit_idx=0.
  - rx_s==1: glitch; return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, sample rx_s.
  - Shift right: shift <= {rx_s, shift[7:1]}.
  - bit_idx increments; after the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s==1 and full_n==1: register data_o<=shift and wr<=1; go to IDLE.
  - rx_s==1 and full_n==0: no wr, data_o unchanged, overrun<=1; go to IDLE.
  - rx_s==0: frame_err<=1 for one cycle, no wr; go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s==1, then go to IDLE. This prevents a MIDI break from retriggering frames.
- Output timing:
  - wr and frame_err are registered one-cycle pulses, high in the cycle after the stop sample edge.
  - data_o holds its value until the next accepted byte.
  - Latency from rx_i falling edge to wr high = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 for input phase). This is 155 cycles at the default.
- full_n is sampled only on the stop-sample cycle.
- Back-to-back frames: IDLE detects the next start bit on the cycle after the stop sample. Frames with a one-bit stop and no idle gap must be received without loss.
- Overrun: set on a drop. Cleared by clr_err when no drop occurs in the same cycle; set has priority over clear.
- Counter wrap: the counter resets to 0 at every sample point and never free-runs past CLKS_PER_BIT-1.

Decomposition:
- Package midi_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE};
  - localparam MIDI_DATA_BITS = 8;
  - localparam MIDI_IDLE_LEVEL = 1'b1.
- Sub-module sync_2ff: a 1-bit, two-flop synchroniser with async active-low reset and reset value parameter RST_VAL (1 here). It is reusable for the other MIDI IN ports.

Test Plan:
All tests use CLKS_PER_BIT=16.
- Reset: rx_i=1, pulse reset low mid-simulation -> data_o=8'h00, wr=0, frame_err=0, overrun=0, busy=0 immediately (asynchronous).
- Single frame: 0x90, full_n=1 -> exactly one wr pulse 155±1 cycles after the start edge; data_o=8'h90; busy low afterwards.
- Back-to-back 0x3C then 0x7F, no idle gap -> two wr pulses 160 cycles apart with data_o=8'h3C then 8'h7F; no frame_err.
- Glitch: rx_i low for 4 cycles, then high -> no wr, no frame_err; state returns to IDLE within 12 cycles.
- Framing error: 0x55 with rx_i held low for 48 cycles at the stop bit -> one frame_err pulse, no wr, busy high until rx_i returns high. A following 0x01 frame is received with data_o=8'h01.
- Overrun:
  - full_n=0 during 0xAA -> no wr, overrun=1, and it stays set through a following 0x12 received with full_n=1 (wr, data_o=8'h12).
  - clr_err pulse -> overrun=0.
  - reset asserted mid-frame -> no wr; the next frame is received normally.
